// File: rtl/sram_like_inst_responder_if.sv
// Dual-word sram-like instruction bus between the fetch initiator and a
// memory responder. The initiator drives requests; the responder answers
// with an address handshake and up to two read words per fetch.
interface sram_like_inst_responder_if;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic        inst_addr_ok;
   logic        inst_data_ok1;
   logic        inst_data_ok2;
   logic [31:0] inst_rdata1;
   logic [31:0] inst_rdata2;

   modport master (
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      input  inst_addr_ok, inst_data_ok1, inst_data_ok2, inst_rdata1, inst_rdata2
   );

   modport slave (
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
      output inst_addr_ok, inst_data_ok1, inst_data_ok2, inst_rdata1, inst_rdata2
   );
endinterface

// File: rtl/sram_like_inst_responder.sv
// Instruction-memory responder for the dual-word sram-like fetch bus.
// Fetches read mem[idx] and mem[idx+1] and return them LATENCY cycles after
// acceptance; word writes are acknowledged through the same in-order pipeline.
// A side preload port writes the memory directly and wins same-word collisions.
// Optional feature: define RESP_RANDOM_STALL_EN to gate inst_addr_ok with a
// 16-bit LFSR (about one cycle in four refused) for initiator stress testing.
module sram_like_inst_responder #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   sram_like_inst_responder_if.slave bus,
   input  logic                      mem_we,
   input  logic [ADDR_W-1:0]         mem_waddr,
   input  logic [31:0]               mem_wdata
);
   localparam int DEPTH = 1 << ADDR_W;
   localparam int MID   = (LATENCY > 1) ? LATENCY - 1 : 1;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_nxt;
   logic              addr_ok;
   logic              accept;
   logic              acc_write;

   // Per-stage control (reset) and data (not reset) registers
   logic              vld_p  [LATENCY];
   logic              wr_p   [LATENCY];
   logic              pair_p [LATENCY];
   logic [31:0]       rd1_p  [MID];
   logic [31:0]       rd2_p  [MID];

   // Values presented to the input of each stage
   logic              in_vld  [LATENCY];
   logic              in_wr   [LATENCY];
   logic              in_pair [LATENCY];
   logic [31:0]       in_rd1  [LATENCY];
   logic [31:0]       in_rd2  [LATENCY];

   // Output holding registers; only reloaded by a fetch response
   logic [31:0]       rdata1_q;
   logic [31:0]       rdata2_q;

   // Size field and address bits outside the word index carry no meaning here
   logic              unused_bits;
   assign unused_bits = ^{bus.inst_size, bus.inst_addr[31:ADDR_W+2], bus.inst_addr[1:0]};

   assign idx     = bus.inst_addr[ADDR_W+1:2];
   assign idx_nxt = idx + ADDR_W'(1);

`ifdef RESP_RANDOM_STALL_EN
   logic [15:0] lfsr;

   // Free-running Fibonacci LFSR (taps 16,14,13,11) that gates acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr <= 16'hACE1;
      end else begin
         lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      end
   end

   assign addr_ok = (lfsr[1:0] != 2'b00);
`else
   assign addr_ok = 1'b1;
`endif

   // Nothing is accepted while reset is held, so no write or fetch sneaks in
   assign accept    = bus.inst_req && addr_ok && !rst;
   assign acc_write = accept && bus.inst_wr;

   // Memory update: the preload port takes priority over a bus write to the same word
   always_ff @(posedge clk) begin
      if (acc_write && !(mem_we && (mem_waddr == idx))) begin
         mem[idx] <= bus.inst_wdata;
      end
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   // Stage inputs: stage 0 takes the request and the pre-write memory words,
   // later stages take the previous stage
   always_comb begin
      in_vld[0]  = accept;
      in_wr[0]   = bus.inst_wr;
      in_pair[0] = !bus.inst_wr && (bus.inst_addr[4:2] != 3'b111);
      in_rd1[0]  = mem[idx];
      in_rd2[0]  = mem[idx_nxt];
      for (int k = 1; k < LATENCY; k++) begin
         in_vld[k]  = vld_p[k-1];
         in_wr[k]   = wr_p[k-1];
         in_pair[k] = pair_p[k-1];
         in_rd1[k]  = rd1_p[k-1];
         in_rd2[k]  = rd2_p[k-1];
      end
   end

   // Control pipeline: reset discards everything in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < LATENCY; k++) begin
            vld_p[k]  <= 1'b0;
            wr_p[k]   <= 1'b0;
            pair_p[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < LATENCY; k++) begin
            vld_p[k]  <= in_vld[k];
            wr_p[k]   <= in_wr[k];
            pair_p[k] <= in_pair[k];
         end
      end
   end

   // Intermediate data stages: load only when a fetch passes through
   always_ff @(posedge clk) begin
      for (int k = 0; k < LATENCY - 1; k++) begin
         if (in_vld[k] && !in_wr[k]) begin
            rd1_p[k] <= in_rd1[k];
            rd2_p[k] <= in_rd2[k];
         end
      end
   end

   // Final stage data: visible outputs hold between fetch responses
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata1_q <= 32'h0;
         rdata2_q <= 32'h0;
      end else if (in_vld[LATENCY-1] && !in_wr[LATENCY-1]) begin
         rdata1_q <= in_rd1[LATENCY-1];
         rdata2_q <= in_rd2[LATENCY-1];
      end
   end

   assign bus.inst_addr_ok  = addr_ok;
   assign bus.inst_data_ok1 = vld_p[LATENCY-1];
   assign bus.inst_data_ok2 = vld_p[LATENCY-1] && pair_p[LATENCY-1] && !wr_p[LATENCY-1];
   assign bus.inst_rdata1   = rdata1_q;
   assign bus.inst_rdata2   = rdata2_q;
endmodule

// File: tb/tb_sram_like_inst_responder.sv
// Bench for sram_like_inst_responder: a queue-based response model checked on
// every falling edge, plus directed scenarios with literal expected values.
module tb_sram_like_inst_responder;
   localparam int ADDR_W  = 12;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              mem_we = 1'b0;
   logic [ADDR_W-1:0] mem_waddr = '0;
   logic [31:0]       mem_wdata = '0;

   sram_like_inst_responder_if bus();

   sram_like_inst_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .mem_we    (mem_we),
      .mem_waddr (mem_waddr),
      .mem_wdata (mem_wdata)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int acc_cnt = 0;
   int pulses = 0;
   int req_cycles = 0;
   int stall_cycles = 0;

   logic [31:0] mmem [DEPTH];

   typedef struct {
      int          due;
      bit          wr;
      bit          pair;
      logic [31:0] d1;
      logic [31:0] d2;
   } resp_t;

   resp_t q[$];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Model: record each accepted request with the cycle its response is due
   always @(posedge clk) begin : monitor
      int    ix;
      resp_t r;
      cyc++;
      if (rst) begin
         q.delete();
      end else if (bus.inst_req) begin
         req_cycles++;
         if (!bus.inst_addr_ok) begin
            stall_cycles++;
         end else begin
            ix     = int'(bus.inst_addr[ADDR_W+1:2]);
            r.due  = cyc + LATENCY - 1;
            r.wr   = bus.inst_wr;
            r.pair = !bus.inst_wr && (bus.inst_addr[4:2] != 3'b111);
            r.d1   = mmem[ix];
            r.d2   = mmem[(ix + 1) % DEPTH];
            q.push_back(r);
            acc_cnt++;
            if (bus.inst_wr) mmem[ix] = bus.inst_wdata;
         end
      end
      if (mem_we) mmem[mem_waddr] = mem_wdata;
   end

   logic [31:0] hold1 = '0;
   logic [31:0] hold2 = '0;
   bit          hold_ok = 1'b0;

   // Compare DUT outputs against the model on every falling edge
   always @(negedge clk) begin : compare
      resp_t r;
      if (rst) begin
         q.delete();
         check("rst_data_ok1", {31'b0, bus.inst_data_ok1}, 32'd0);
         check("rst_data_ok2", {31'b0, bus.inst_data_ok2}, 32'd0);
         check("rst_rdata1", bus.inst_rdata1, 32'h0);
         check("rst_rdata2", bus.inst_rdata2, 32'h0);
         hold1   = '0;
         hold2   = '0;
         hold_ok = 1'b1;
      end else begin
         if (bus.inst_data_ok1) pulses++;
         if ((q.size() > 0) && (q[0].due == cyc)) begin
            r = q.pop_front();
            check("data_ok1", {31'b0, bus.inst_data_ok1}, 32'd1);
            check("data_ok2", {31'b0, bus.inst_data_ok2}, {31'b0, r.pair});
            if (!r.wr) begin
               check("rdata1", bus.inst_rdata1, r.d1);
               if (r.pair) check("rdata2", bus.inst_rdata2, r.d2);
               hold1   = r.d1;
               hold2   = r.d2;
               hold_ok = 1'b1;
            end else begin
               hold_ok = 1'b0;
            end
         end else begin
            check("idle_data_ok1", {31'b0, bus.inst_data_ok1}, 32'd0);
            check("idle_data_ok2", {31'b0, bus.inst_data_ok2}, 32'd0);
            if (hold_ok) begin
               check("hold_rdata1", bus.inst_rdata1, hold1);
               check("hold_rdata2", bus.inst_rdata2, hold2);
            end
         end
      end
   end

   task automatic preload(int a, logic [31:0] d);
      mem_we    = 1'b1;
      mem_waddr = ADDR_W'(a);
      mem_wdata = d;
      @(posedge clk);
      #1;
      mem_we = 1'b0;
   endtask

   // Present one request and hold it until accepted; returns 1 time unit after the accept edge
   task automatic req_op(bit wr, logic [31:0] addr, logic [31:0] wdata, logic [1:0] size);
      int n;
      n = 0;
      bus.inst_req   = 1'b1;
      bus.inst_wr    = wr;
      bus.inst_addr  = addr;
      bus.inst_wdata = wdata;
      bus.inst_size  = size;
      while (1) begin
         @(posedge clk);
         if (bus.inst_addr_ok) break;
         n++;
         if (n > 100) begin
            errors++;
            $display("FAIL accept_timeout actual=%0d cycles required=accept", n);
            break;
         end
      end
      #1;
      bus.inst_req = 1'b0;
      bus.inst_wr  = 1'b0;
   endtask

   task automatic wait_resp();
      repeat (LATENCY - 1) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic realign();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin : main
      int          p0;
      int          a0;
      int          r0;
      int          s0;
      int          nops;
      logic [31:0] a;
      bus.inst_req   = 1'b0;
      bus.inst_wr    = 1'b0;
      bus.inst_size  = 2'b10;
      bus.inst_addr  = '0;
      bus.inst_wdata = '0;
      rst = 1'b1;
      realign();
      check("rst_addr_ok", {31'b0, bus.inst_addr_ok}, 32'd1);
      for (int i = 0; i < 128; i++) preload(i, 32'hA500_0000 + i);
      preload(32'h10, 32'h1111_1111);
      preload(32'h11, 32'h2222_2222);
      preload(7, 32'h7777_7777);
      rst = 1'b0;
      repeat (2) realign();

`ifndef RESP_RANDOM_STALL_EN
      // Aliased segment address, full pair
      req_op(1'b0, 32'hBFC0_0040, 32'h0, 2'b10);
      wait_resp();
      check("t1_ok1", {31'b0, bus.inst_data_ok1}, 32'd1);
      check("t1_ok2", {31'b0, bus.inst_data_ok2}, 32'd1);
      check("t1_rdata1", bus.inst_rdata1, 32'h1111_1111);
      check("t1_rdata2", bus.inst_rdata2, 32'h2222_2222);
      realign();

      // Line end: single word only
      req_op(1'b0, 32'h0000_001C, 32'h0, 2'b10);
      wait_resp();
      check("t2_ok1", {31'b0, bus.inst_data_ok1}, 32'd1);
      check("t2_ok2", {31'b0, bus.inst_data_ok2}, 32'd0);
      check("t2_rdata1", bus.inst_rdata1, 32'h7777_7777);
      realign();

      // Write then fetch the same word on the next cycle
      req_op(1'b1, 32'h0000_0020, 32'hDEAD_BEEF, 2'b10);
      req_op(1'b0, 32'h0000_0020, 32'h0, 2'b10);
      @(negedge clk);
      check("t3_wr_ok1", {31'b0, bus.inst_data_ok1}, 32'd1);
      check("t3_wr_ok2", {31'b0, bus.inst_data_ok2}, 32'd0);
      @(negedge clk);
      check("t3_rd_ok2", {31'b0, bus.inst_data_ok2}, 32'd1);
      check("t3_rdata1", bus.inst_rdata1, 32'hDEAD_BEEF);
      check("t3_rdata2", bus.inst_rdata2, 32'hA500_0009);
      realign();

      // Fetch colliding with a same-cycle preload returns the old word
      mem_we = 1'b1; mem_waddr = ADDR_W'(9); mem_wdata = 32'h9999_0000;
      req_op(1'b0, 32'h0000_0024, 32'h0, 2'b10);
      mem_we = 1'b0;
      wait_resp();
      check("t3c_rdata1_old", bus.inst_rdata1, 32'hA500_0009);
      check("t3c_rdata2", bus.inst_rdata2, 32'hA500_000A);
      realign();

      // Bus write and preload to the same word: preload wins
      mem_we = 1'b1; mem_waddr = ADDR_W'(10); mem_wdata = 32'h0BAD_F00D;
      req_op(1'b1, 32'h0000_0028, 32'h1234_5678, 2'b10);
      mem_we = 1'b0;
      req_op(1'b0, 32'h0000_0024, 32'h0, 2'b10);
      @(negedge clk);
      @(negedge clk);
      check("t3w_rdata1", bus.inst_rdata1, 32'h9999_0000);
      check("t3w_rdata2", bus.inst_rdata2, 32'h0BAD_F00D);
      realign();

      // Four back-to-back fetches
      p0 = pulses;
      req_op(1'b0, 32'h0000_0000, 32'h0, 2'b10);
      req_op(1'b0, 32'h0000_0008, 32'h0, 2'b10);
      req_op(1'b0, 32'h0000_0010, 32'h0, 2'b10);
      req_op(1'b0, 32'h0000_0018, 32'h0, 2'b10);
      repeat (LATENCY + 2) realign();
      check("t4_pulses", pulses - p0, 32'd4);
      check("t4_last_rdata1", bus.inst_rdata1, 32'hA500_0006);
      check("t4_last_rdata2", bus.inst_rdata2, 32'h7777_7777);

      // Reset with two fetches in flight; the earlier write must persist
      req_op(1'b1, 32'h0000_0030, 32'hFEED_FACE, 2'b10);
      req_op(1'b0, 32'h0000_0000, 32'h0, 2'b10);
      req_op(1'b0, 32'h0000_0008, 32'h0, 2'b10);
      rst = 1'b1;
      p0 = pulses;
      repeat (3) realign();
      rst = 1'b0;
      repeat (6) realign();
      check("t5_no_pulse", pulses - p0, 32'd0);
      check("t5_rdata1_zero", bus.inst_rdata1, 32'h0);
      req_op(1'b0, 32'h0000_0030, 32'h0, 2'b10);
      wait_resp();
      check("t5_persist", bus.inst_rdata1, 32'hFEED_FACE);
      realign();
`endif

      // Continuous traffic with random size field and aliased upper bits
`ifdef RESP_RANDOM_STALL_EN
      nops = 750;
`else
      nops = 200;
`endif
      p0 = pulses;
      a0 = acc_cnt;
      r0 = req_cycles;
      s0 = stall_cycles;
      for (int i = 0; i < nops; i++) begin
         a = $urandom();
         a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 63));
         req_op(($urandom_range(0, 3) == 0), a, $urandom(), 2'($urandom_range(0, 3)));
      end
      repeat (LATENCY + 3) realign();
      check("t6_resp_count", pulses - p0, acc_cnt - a0);
      check("t6_accept_count", acc_cnt - a0, nops);
`ifdef RESP_RANDOM_STALL_EN
      check("t6_stall_ratio_ok",
            {31'b0, ((stall_cycles - s0) * 100 >= (req_cycles - r0) * 15) &&
                    ((stall_cycles - s0) * 100 <= (req_cycles - r0) * 35)}, 32'd1);
`else
      check("t6_no_stall", stall_cycles - s0, 32'd0);
`endif
      check("t6_queue_empty", q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_like_inst_responder.md
# sram_like_inst_responder

Responder end of the dual-word sram-like instruction interface driven by the core's fetch path. It accepts fetch requests, reads a word pair from an internal word-addressed memory and returns both words after a fixed latency. It also serves word writes and offers a side preload port. It is used as the instruction-memory model in core-level simulation, and as the template for the on-chip boot ROM responder.

## Interface
Parameters:
- ADDR_W, 12, word-index width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2, cycles from request acceptance to `inst_data_ok1`; legal range 1..8.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- inst_req  input  1  request valid.
- inst_wr  input  1  1 = write, 0 = fetch.
- inst_size  input  2  access size; only 2'b10 is honoured, other values are treated as 2'b10.
- inst_addr  input  32  byte address; bits [1:0] ignored.
- inst_wdata  input  32  write data.
- inst_addr_ok  output  1  request accepted this cycle when high together with `inst_req`.
- inst_data_ok1  output  1  one-cycle pulse: `inst_rdata1` valid, or write complete.
- inst_data_ok2  output  1  one-cycle pulse: `inst_rdata2` valid.
- inst_rdata1  output  32  word at the request address.
- inst_rdata2  output  32  word at the request address + 4.
- mem_we  input  1  preload write enable.
- mem_waddr  input  ADDR_W  preload word index.
- mem_wdata  input  32  preload data.

## Operation
- Word index is `idx = inst_addr[ADDR_W+1:2]`. Upper address bits are ignored, so all segments alias.
- `inst_addr_ok` is combinational and equals 1 when the random-stall gate allows it.
- A request is accepted on a cycle where `inst_req && inst_addr_ok`.
- The responder never back-pressures data, and the initiator must accept every `data_ok` pulse.
- Accepted fetch:
  - Synchronous read of `mem[idx]` and `mem[idx+1]` into stage 0 of a LATENCY-deep valid/data shift pipeline.
  - The `idx+1` read wraps modulo 2^ADDR_W.
  - Stage 0 also captures `pair = (inst_addr[4:2] != 3'b111)`.
- Accepted write:
  - `mem[idx] <= inst_wdata` at the accept edge.
  - The write enters the pipeline with `pair = 0` and no read data.
- Pipeline exit:
  - `inst_data_ok1 = valid_last`.
  - `inst_data_ok2 = valid_last && pair_last && !wr_last`.
- Outputs of the last stage are registered. Responses are strictly in request order, and one request can be accepted per cycle.
- When `inst_data_ok1` is low, `inst_rdata1` and `inst_rdata2` hold their previous values.
- Same-cycle collisions:
  - A fetch and a write (`inst_wr` or `mem_we`) to the same word return the old data (read-before-write).
  - `mem_we` and an accepted `inst_wr` to the same word: `mem_we` wins.
  - `mem_we` never stalls requests.
- Memory contents are not reset.

## Timing
- Reset values:
  - `inst_addr_ok` = 1 (0 if the LFSR gate is low; the LFSR resets to 16'hACE1).
  - `inst_data_ok1` = 0, `inst_data_ok2` = 0.
  - `inst_rdata1` = 0, `inst_rdata2` = 0.
  - All pipeline valid bits = 0.
- Latency: a request accepted at edge N gives `inst_data_ok1` high in the cycle following edge N+LATENCY-1, i.e. LATENCY cycles after the accept cycle.
- Back-to-back accepts produce back-to-back `data_ok` pulses.
- Reset mid-operation: all in-flight responses are discarded and no `data_ok` pulse follows the reset release. Writes already accepted before reset persist in memory.

## Configuration
- RESP_RANDOM_STALL_EN:
  - Defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle, and `inst_addr_ok = (lfsr[1:0] != 2'b00)`. Requests during gated cycles are not accepted and must be held by the initiator.
  - Undefined: `inst_addr_ok` is constant 1 outside reset and the LFSR is not built.

## Test plan
- Preload `mem[0x10]=0x11111111` and `mem[0x11]=0x22222222`, LATENCY=2, then fetch addr 0xBFC00040 → two cycles after accept: `data_ok1=data_ok2=1`, rdata1=0x11111111, rdata2=0x22222222.
- Fetch addr 0x0000001C (line end) → `data_ok1=1`, `data_ok2=0`, rdata1=mem[7].
- Write 0xDEADBEEF to addr 0x20, then fetch 0x20 on the next cycle → write `data_ok1` pulse with `data_ok2=0`, then the fetch returns rdata1=0xDEADBEEF. The fetch is also checked against a same-cycle `mem_we` collision, where the old value must be returned.
- Four back-to-back fetches 0x0, 0x8, 0x10, 0x18 → four consecutive `data_ok1` pulses, in order, with correct pairs.
- Assert rst while two fetches are in flight → no `data_ok` pulse after release, and all outputs are 0 during reset.
- With RESP_RANDOM_STALL_EN defined and continuous requests for 1000 cycles → every accept gets exactly one response, `addr_ok` is low in about 25% of cycles, and no request is lost or duplicated.
